// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with 3-sample majority vote feeding a small byte FIFO
// Sticky frame_err/overrun flags; a set event beats clear_err in the same cycle.
module uart_rx_fifo #(
  parameter int DIV        = 217,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  RX,
  output logic [7:0]            data,
  output logic                  valid,
  input  logic                  pop,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  clear_err
);

  localparam int CW    = $clog2(DIV);
  localparam int H     = DIV / 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CW-1:0]         C_LO  = CW'(H - 1);
  localparam logic [CW-1:0]         C_MID = CW'(H);
  localparam logic [CW-1:0]         C_HI  = CW'(H + 1);
  localparam logic [CW-1:0]         C_TOP = CW'(DIV - 1);
  localparam logic [CW-1:0]         C_ONE = CW'(1);
  localparam logic [DEPTH_LOG2:0]   FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT1  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR1  = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                state, state_nx;
  logic                  rx_m, rx_s;
  logic [CW-1:0]         cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;
  logic                  s_lo, s_mid;
  logic                  maj, at_hi, wrap, full, do_pop;
  logic                  push, set_fe, set_ov;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;

  assign maj    = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
  assign at_hi  = (cnt == C_HI);
  assign wrap   = (cnt == C_TOP);
  assign full   = (count == FULL);
  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign data   = mem[rptr];

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    set_fe   = 1'b0;
    set_ov   = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_nx = START;
      START: begin
        if (at_hi && maj) state_nx = IDLE;
        else if (wrap)    state_nx = DATA;
      end
      DATA:  if (wrap && bit_idx == 3'd7) state_nx = STOP;
      STOP: begin
        if (at_hi) begin
          if (maj) begin
            state_nx = IDLE;
            // A pop in the same cycle frees the slot being written.
            if (!full || do_pop) push = 1'b1;
            else                 set_ov = 1'b1;
          end else begin
            state_nx = BREAK;
            set_fe   = 1'b1;
          end
        end
      end
      BREAK: if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      s_lo      <= 1'b1;
      s_mid     <= 1'b1;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_m  <= RX;
      rx_s  <= rx_m;
      state <= state_nx;

      if (state == IDLE || state == BREAK || state_nx == IDLE || wrap) cnt <= '0;
      else                                                             cnt <= cnt + C_ONE;

      if (cnt == C_LO)  s_lo  <= rx_s;
      if (cnt == C_MID) s_mid <= rx_s;

      if (state == START && wrap) bit_idx <= '0;
      if (state == DATA) begin
        if (at_hi) shreg   <= {maj, shreg[7:1]};
        if (wrap)  bit_idx <= bit_idx + 3'd1;
      end

      if (push)   wptr <= wptr + PTR1;
      if (do_pop) rptr <= rptr + PTR1;
      case ({push, do_pop})
        2'b10:   count <= count + CNT1;
        2'b01:   count <= count - CNT1;
        default: count <= count;
      endcase

      frame_err <= set_fe | (frame_err & ~clear_err);
      overrun   <= set_ov | (overrun & ~clear_err);
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem[wptr] <= shreg;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo at DIV=16, DEPTH_LOG2=2
module tb_uart_rx_fifo;

  logic       Clock = 1'b0;
  logic       Reset, RX, pop, clear_err;
  logic [7:0] data;
  logic       valid, frame_err, overrun;
  logic [2:0] count;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fifo #(.DIV(16), .DEPTH_LOG2(2)) dut (
    .Clock(Clock), .Reset(Reset), .RX(RX), .data(data), .valid(valid), .pop(pop),
    .count(count), .frame_err(frame_err), .overrun(overrun), .clear_err(clear_err)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // One 16-clock slot per bit; pop/Reset may be injected at a given clock of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_cyc, input int rst_cyc);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 160; k++) begin
      if (k == rst_cyc) begin
        Reset = 1'b1;
        RX    = 1'b1;
        idle(1);
        Reset = 1'b0;
        return;
      end
      RX  = fr[k / 16];
      pop = (k == pop_cyc);
      idle(1);
    end
    pop = 1'b0;
    if (!stop) idle(4);
    RX = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_data"}, data, exp);
    pop = 1'b1;
    idle(1);
    pop = 1'b0;
  endtask

  task automatic check_flags(input string tag, input int c, input logic fe, input logic ov);
    check({tag, "_count"}, count, c);
    check({tag, "_valid"}, valid, (c != 0));
    check({tag, "_frame_err"}, frame_err, fe);
    check({tag, "_overrun"}, overrun, ov);
  endtask

  initial begin
    Reset = 1'b1; RX = 1'b1; pop = 1'b0; clear_err = 1'b0;
    idle(3);
    Reset = 1'b0;
    check_flags("reset", 0, 0, 0);

    // single good frame, then pop
    send_frame(8'hA5, 1'b1, -1, -1);
    idle(4);
    check_flags("a5", 1, 0, 0);
    pop_check("a5_pop", 8'hA5);
    check_flags("a5_after_pop", 0, 0, 0);

    // 3-clock glitch rejected
    RX = 1'b0; idle(3); RX = 1'b1; idle(30);
    check_flags("glitch", 0, 0, 0);

    // stop bit low -> frame error, recovers for next frame
    send_frame(8'h3C, 1'b0, -1, -1);
    idle(4);
    check_flags("ferr", 0, 1, 0);
    send_frame(8'h11, 1'b1, -1, -1);
    idle(4);
    check_flags("ferr_next", 1, 1, 0);
    pop_check("x11_pop", 8'h11);
    clear_err = 1'b1; idle(1); clear_err = 1'b0;
    check_flags("ferr_clr", 0, 0, 0);

    // overfill: fifth byte dropped
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1, -1);
      idle(2);
    end
    check_flags("ovr", 4, 0, 1);
    pop_check("ovr_pop1", 8'h01);
    pop_check("ovr_pop2", 8'h02);
    pop_check("ovr_pop3", 8'h03);
    pop_check("ovr_pop4", 8'h04);
    check_flags("ovr_empty", 0, 0, 1);

    // reset during data bit 3 with a byte queued and overrun set
    send_frame(8'h99, 1'b1, -1, -1);
    idle(4);
    check_flags("pre_rst", 1, 0, 1);
    send_frame(8'hC3, 1'b1, -1, 70);
    check_flags("mid_rst", 0, 0, 0);
    idle(20);
    check_flags("mid_rst_idle", 0, 0, 0);
    send_frame(8'h5A, 1'b1, -1, -1);
    idle(4);
    check_flags("x5a", 1, 0, 0);
    pop_check("x5a_pop", 8'h5A);
    idle(40);
    check_flags("x5a_once", 0, 0, 0);

    // full FIFO with pop in the stop-sample cycle
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h21 + 8'(i), 1'b1, -1, -1);
      idle(2);
    end
    check_flags("full", 4, 0, 0);
    send_frame(8'h77, 1'b1, 156, -1);
    idle(4);
    check_flags("full_pp", 4, 0, 0);
    pop_check("pp_pop1", 8'h22);
    pop_check("pp_pop2", 8'h23);
    pop_check("pp_pop3", 8'h24);
    pop_check("pp_pop4", 8'h77);
    check_flags("pp_empty", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
